// File: rtl/button_debouncer.sv
// Per-channel synchronizer, debouncer, edge-pulse and long-press detector for raw push-buttons.
// Every register is synchronous to clk; rst is synchronous, active-high and overrides all updates.
//
// state       | meaning
// ------------|--------------------------------------------------------------
// LOW         | level 0, synchronized input agrees (dcnt == 0)
// ARMING_HIGH | level 0, input has read 1 for dcnt consecutive cycles
// HIGH        | level 1, synchronized input agrees (dcnt == 0)
// ARMING_LOW  | level 1, input has read 0 for dcnt consecutive cycles
module button_debouncer #(
    parameter int             N             = 4,
    parameter int             STABLE_CYCLES = 50000,
    parameter int             HOLD_CYCLES   = 25000000,
    parameter logic [N-1:0]   INVERT        = {N{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release,
    output logic [N-1:0] btn_hold
);

    localparam int DW = $clog2(STABLE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] D_TC  = DW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX = HW'(HOLD_CYCLES);

    // Encoding is (level, dcnt != 0), so the state is derived rather than stored.
    typedef enum logic [1:0] {
        LOW         = 2'b00,
        ARMING_HIGH = 2'b01,
        HIGH        = 2'b10,
        ARMING_LOW  = 2'b11
    } state_t;

    logic [N-1:0] s1, s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw ^ INVERT;
            s2 <= s1;
        end
    end

    for (genvar ch = 0; ch < N; ch++) begin : g_ch
        state_t        state;
        logic          level, level_d;
        logic [DW-1:0] dcnt, dcnt_d;
        logic [HW-1:0] hcnt, hcnt_d;
        logic          press, press_d;
        logic          release_q, release_d;
        logic          hold, hold_d;

        assign state = state_t'({level, dcnt != '0});

        always_ff @(posedge clk) begin
            if (rst) begin
                level     <= 1'b0;
                dcnt      <= '0;
                hcnt      <= '0;
                press     <= 1'b0;
                release_q <= 1'b0;
                hold      <= 1'b0;
            end else begin
                level     <= level_d;
                dcnt      <= dcnt_d;
                hcnt      <= hcnt_d;
                press     <= press_d;
                release_q <= release_d;
                hold      <= hold_d;
            end
        end

        always_comb begin
            level_d = level;
            dcnt_d  = '0;
            case (state)
                LOW, ARMING_HIGH: begin
                    if (s2[ch]) begin
                        if (dcnt == D_TC) level_d = 1'b1;
                        else              dcnt_d  = dcnt + DW'(1);
                    end
                end
                HIGH, ARMING_LOW: begin
                    if (!s2[ch]) begin
                        if (dcnt == D_TC) level_d = 1'b0;
                        else              dcnt_d  = dcnt + DW'(1);
                    end
                end
                default: begin
                    level_d = 1'b0;
                    dcnt_d  = '0;
                end
            endcase
        end

        // Hold is qualified with the next level so it drops on the same edge as the level.
        always_comb begin
            press_d   = level_d & ~level;
            release_d = ~level_d & level;
            if (!level)             hcnt_d = '0;
            else if (hcnt == H_MAX) hcnt_d = hcnt;
            else                    hcnt_d = hcnt + HW'(1);
            hold_d    = level_d & (hcnt_d == H_MAX);
        end

        assign btn_level[ch]   = level;
        assign btn_press[ch]   = press;
        assign btn_release[ch] = release_q;
        assign btn_hold[ch]    = hold;
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus randomized bursts, all checked
// cycle by cycle against a run-length behavioural model of the debouncer.
module tb_button_debouncer;
    localparam int          N   = 2;
    localparam int          S   = 4;
    localparam int          H   = 10;
    localparam logic [1:0]  INV = 2'b10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_raw = 2'b10;
    logic [1:0] btn_level, btn_press, btn_release, btn_hold;

    int checks = 0;
    int passes = 0;

    logic [1:0] m_d1, m_d2, m_level, m_press, m_rel, m_hold;
    int m_run [2];
    int m_hi  [2];

    button_debouncer #(.N(N), .STABLE_CYCLES(S), .HOLD_CYCLES(H), .INVERT(INV)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_hold   (btn_hold)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, advance the model across the edge, return at the falling edge.
    task automatic tick(input logic [1:0] raw, input logic r);
        logic [1:0] s2_now;
        logic       old;
        btn_raw = raw;
        rst     = r;
        @(posedge clk);
        if (r) begin
            m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_hold = '0;
            for (int c = 0; c < N; c++) begin m_run[c] = 0; m_hi[c] = 0; end
        end else begin
            s2_now = m_d2;
            m_d2   = m_d1;
            m_d1   = raw ^ INV;
            for (int c = 0; c < N; c++) begin
                old = m_level[c];
                if (s2_now[c] != old) begin
                    m_run[c]++;
                    if (m_run[c] == S) begin
                        m_level[c] = ~old;
                        m_run[c]   = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_press[c] = m_level[c] & ~old;
                m_rel[c]   = ~m_level[c] & old;
                if (!m_level[c] || !old) m_hi[c] = 0;
                else                     m_hi[c]++;
                m_hold[c]  = m_level[c] && (m_hi[c] >= H);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(2'b10, 1'b1);
            checks++;
            if ({btn_level, btn_press, btn_release, btn_hold} !== 8'h00)
                $display("FAIL reset_state got=%h want=00", {btn_level, btn_press, btn_release, btn_hold});
            else passes++;
        end
    endtask

    task automatic test_hold_release();
        int lvl_at = -1, hold_at = -1, prs = 0, rels = 0, lfall = -1, hfall = -1;
        for (int i = 0; i < 20; i++) begin
            tick(2'b11, 1'b0);
            checks++;
            if ({btn_level, btn_press, btn_release, btn_hold} !== {m_level, m_press, m_rel, m_hold})
                $display("FAIL press_model i=%0d got=%h want=%h", i,
                         {btn_level, btn_press, btn_release, btn_hold}, {m_level, m_press, m_rel, m_hold});
            else passes++;
            if (btn_level[0] && lvl_at < 0) lvl_at = i;
            if (btn_hold[0] && hold_at < 0) hold_at = i;
            prs  += int'(btn_press[0]);
            rels += int'(btn_release[0]);
        end
        checks++; if (lvl_at !== 5)  $display("FAIL press_latency got=%0d want=5", lvl_at); else passes++;
        checks++; if (prs !== 1)     $display("FAIL press_count got=%0d want=1", prs); else passes++;
        checks++; if (rels !== 0)    $display("FAIL no_release got=%0d want=0", rels); else passes++;
        checks++; if (hold_at !== 15) $display("FAIL hold_latency got=%0d want=15", hold_at); else passes++;
        rels = 0;
        for (int i = 0; i < 10; i++) begin
            tick(2'b10, 1'b0);
            checks++;
            if ({btn_level, btn_press, btn_release, btn_hold} !== {m_level, m_press, m_rel, m_hold})
                $display("FAIL release_model i=%0d got=%h want=%h", i,
                         {btn_level, btn_press, btn_release, btn_hold}, {m_level, m_press, m_rel, m_hold});
            else passes++;
            if (!btn_level[0] && lfall < 0) lfall = i;
            if (!btn_hold[0] && hfall < 0)  hfall = i;
            rels += int'(btn_release[0]);
        end
        checks++; if (lfall !== 5)     $display("FAIL release_latency got=%0d want=5", lfall); else passes++;
        checks++; if (hfall !== lfall) $display("FAIL hold_fall got=%0d want=%0d", hfall, lfall); else passes++;
        checks++; if (rels !== 1)      $display("FAIL release_count got=%0d want=1", rels); else passes++;
    endtask

    task automatic test_bounce();
        logic pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int lvl_at = -1, prs = 0;
        for (int i = 0; i < 20; i++) begin
            tick({1'b1, (i < 9) ? pat[i] : 1'b1}, 1'b0);
            checks++;
            if ({btn_level, btn_press, btn_release, btn_hold} !== {m_level, m_press, m_rel, m_hold})
                $display("FAIL bounce_model i=%0d got=%h want=%h", i,
                         {btn_level, btn_press, btn_release, btn_hold}, {m_level, m_press, m_rel, m_hold});
            else passes++;
            if (btn_level[0] && lvl_at < 0) lvl_at = i;
            prs += int'(btn_press[0]);
        end
        checks++; if (lvl_at !== 10) $display("FAIL bounce_latency got=%0d want=10", lvl_at); else passes++;
        checks++; if (prs !== 1)     $display("FAIL bounce_presses got=%0d want=1", prs); else passes++;
        for (int i = 0; i < 12; i++) tick(2'b10, 1'b0);
    endtask

    task automatic test_active_low();
        int prs = 0, ch0_bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick(2'b10, 1'b0);
            checks++;
            if (btn_level[1] !== 1'b0) $display("FAIL idle_ch1 got=%b want=0", btn_level[1]);
            else passes++;
        end
        for (int i = 0; i < 10; i++) begin
            tick(2'b00, 1'b0);
            checks++;
            if ({btn_level, btn_press, btn_release, btn_hold} !== {m_level, m_press, m_rel, m_hold})
                $display("FAIL active_low_model i=%0d got=%h want=%h", i,
                         {btn_level, btn_press, btn_release, btn_hold}, {m_level, m_press, m_rel, m_hold});
            else passes++;
            prs     += int'(btn_press[1]);
            ch0_bad += int'(btn_level[0] | btn_press[0]);
        end
        checks++; if (prs !== 1)     $display("FAIL ch1_press got=%0d want=1", prs); else passes++;
        checks++; if (ch0_bad !== 0) $display("FAIL ch0_isolation got=%0d want=0", ch0_bad); else passes++;
        for (int i = 0; i < 12; i++) tick(2'b10, 1'b0);
    endtask

    task automatic test_reset_mid();
        int prs_at = -1;
        for (int i = 0; i < 18; i++) tick(2'b11, 1'b0);
        checks++; if (btn_hold[0] !== 1'b1) $display("FAIL pre_reset_hold got=%b want=1", btn_hold[0]); else passes++;
        tick(2'b11, 1'b1);
        checks++;
        if ({btn_level, btn_press, btn_release, btn_hold} !== 8'h00)
            $display("FAIL mid_reset got=%h want=00", {btn_level, btn_press, btn_release, btn_hold});
        else passes++;
        tick(2'b11, 1'b1);
        tick(2'b11, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            tick(2'b11, 1'b0);
            checks++;
            if ({btn_level, btn_press, btn_release, btn_hold} !== {m_level, m_press, m_rel, m_hold})
                $display("FAIL post_reset_model i=%0d got=%h want=%h", i,
                         {btn_level, btn_press, btn_release, btn_hold}, {m_level, m_press, m_rel, m_hold});
            else passes++;
            if (btn_press[0] && prs_at < 0) prs_at = i;
        end
        checks++; if (prs_at !== 6) $display("FAIL post_reset_press got=%0d want=6", prs_at); else passes++;
        for (int i = 0; i < 12; i++) tick(2'b10, 1'b0);
    endtask

    task automatic test_simultaneous();
        int both = 0, glitch_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick(2'b01, 1'b0);
            checks++;
            if (btn_press[0] !== btn_press[1])
                $display("FAIL simul_press i=%0d got=%b want=%b", i, btn_press[0], btn_press[1]);
            else passes++;
            both += int'(btn_press[0] & btn_press[1]);
        end
        checks++; if (both !== 1) $display("FAIL simul_count got=%0d want=1", both); else passes++;
        for (int i = 0; i < 12; i++) tick(2'b10, 1'b0);
        for (int i = 0; i < 13; i++) begin
            tick((i < 3) ? 2'b11 : 2'b10, 1'b0);
            glitch_bad += int'(btn_level[0] | btn_press[0] | btn_release[0]);
        end
        checks++; if (glitch_bad !== 0) $display("FAIL glitch got=%0d want=0", glitch_bad); else passes++;
    endtask

    task automatic test_random();
        logic [1:0] v;
        logic       r;
        int         len;
        for (int seg = 0; seg < 120; seg++) begin
            v   = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 9);
            r   = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < len; i++) begin
                tick(v, r);
                checks++;
                if ({btn_level, btn_press, btn_release, btn_hold} !== {m_level, m_press, m_rel, m_hold})
                    $display("FAIL random_model seg=%0d got=%h want=%h", seg,
                             {btn_level, btn_press, btn_release, btn_hold}, {m_level, m_press, m_rel, m_hold});
                else passes++;
                checks++;
                if ((btn_press & btn_release) !== 2'b00)
                    $display("FAIL pulse_overlap got=%b want=00", btn_press & btn_release);
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold_release();
        test_bounce();
        test_active_low();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
